// File: rtl/cmp_cal_pkg.sv
// Shared types and helpers for the slicer offset calibration controller.
package cmp_cal_pkg;

    // Calibration sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        VOTE,
        DECIDE,
        DONE
    } cal_state_t;

    // Smallest bit count able to encode values 0 .. value-1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cmp_offset_cal_if.sv
// Sequencer/slicer-facing signal bundle of the offset calibration controller.
interface cmp_offset_cal_if #(
    parameter int NBIT = 6
);
    logic            start;
    logic            abort;
    logic            cmp_out;
    logic            cal_en;
    logic [NBIT-1:0] trim;
    logic            busy;
    logic            done;
    logic            sat;

    // Sequencer / slicer-model side
    modport master (
        output start, abort, cmp_out,
        input  cal_en, trim, busy, done, sat
    );

    // Calibration controller side
    modport slave (
        input  start, abort, cmp_out,
        output cal_en, trim, busy, done, sat
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync2 (
    input  logic clk,
    input  logic rstb,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Shift the async input through two flops to settle metastability
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/cmp_offset_cal.sv
// SAR offset calibration controller: walks a binary trim code from MSB to
// LSB, resolving each bit by a majority vote of the synchronized slicer
// output, then holds the final code for mission mode.
module cmp_offset_cal
    import cmp_cal_pkg::*;
#(
    parameter int              NBIT       = 6,
    parameter int              SETTLE_CYC = 4,
    parameter int              NVOTE      = 3,
    parameter logic [NBIT-1:0] TRIM_RST   = {1'b1, {(NBIT-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rstb,
    cmp_offset_cal_if.slave  cal
);
    localparam int CNT_W = clog2(NVOTE + 1);
    localparam int SET_W = clog2(SETTLE_CYC + 1);
    localparam int KW    = (clog2(NBIT) < 1) ? 1 : clog2(NBIT);

    localparam logic [NBIT-1:0] MSB_CODE = {1'b1, {(NBIT-1){1'b0}}};

    cal_state_t      state_q,     state_d;
    logic [NBIT-1:0] trim_q,      trim_d;
    logic [NBIT-1:0] shadow_q,    shadow_d;
    logic [KW-1:0]   bitIdx_q,    bitIdx_d;
    logic [SET_W-1:0] settleCnt_q, settleCnt_d;
    logic [CNT_W-1:0] voteCnt_q,  voteCnt_d;
    logic [CNT_W-1:0] ones_q,     ones_d;
    logic            calEn_q,     calEn_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;
    logic            sat_q,       sat_d;

    logic            cmpSync;

    sync2 u_cmp_sync (
        .clk  (clk),
        .rstb (rstb),
        .d_i  (cal.cmp_out),
        .q_o  (cmpSync)
    );

    // State, trim code, counters and registered outputs
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            trim_q      <= TRIM_RST;
            shadow_q    <= TRIM_RST;
            bitIdx_q    <= '0;
            settleCnt_q <= '0;
            voteCnt_q   <= '0;
            ones_q      <= '0;
            calEn_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            trim_q      <= trim_d;
            shadow_q    <= shadow_d;
            bitIdx_q    <= bitIdx_d;
            settleCnt_q <= settleCnt_d;
            voteCnt_q   <= voteCnt_d;
            ones_q      <= ones_d;
            calEn_q     <= calEn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
        end
    end

    // Next-state logic; abort overrides every in-run update and restores trim
    always_comb begin
        state_d     = state_q;
        trim_d      = trim_q;
        shadow_d    = shadow_q;
        bitIdx_d    = bitIdx_q;
        settleCnt_d = settleCnt_q;
        voteCnt_d   = voteCnt_q;
        ones_d      = ones_q;
        calEn_d     = calEn_q;
        busy_d      = busy_q;
        done_d      = done_q;
        sat_d       = sat_q;

        case (state_q)
            IDLE: begin
                if (cal.start && !cal.abort) begin
                    state_d     = SETTLE;
                    shadow_d    = trim_q;
                    trim_d      = MSB_CODE;
                    bitIdx_d    = KW'(NBIT - 1);
                    settleCnt_d = '0;
                    calEn_d     = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    sat_d       = 1'b0;
                end
            end
            SETTLE: begin
                if (settleCnt_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d   = VOTE;
                    ones_d    = '0;
                    voteCnt_d = '0;
                end else begin
                    settleCnt_d = settleCnt_q + SET_W'(1);
                end
            end
            VOTE: begin
                ones_d = ones_q + CNT_W'(cmpSync);
                if (voteCnt_q == CNT_W'(NVOTE - 1)) begin
                    state_d = DECIDE;
                end else begin
                    voteCnt_d = voteCnt_q + CNT_W'(1);
                end
            end
            DECIDE: begin
                if (ones_q > CNT_W'(NVOTE / 2)) begin
                    trim_d[bitIdx_q] = 1'b0;
                end
                if (bitIdx_q != '0) begin
                    trim_d[bitIdx_q - KW'(1)] = 1'b1;
                    bitIdx_d    = bitIdx_q - KW'(1);
                    settleCnt_d = '0;
                    state_d     = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                calEn_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                sat_d   = (trim_q == '0) || (trim_q == '1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cal.abort && (state_q == SETTLE || state_q == VOTE || state_q == DECIDE)) begin
            state_d  = IDLE;
            trim_d   = shadow_q;
            bitIdx_d = bitIdx_q;
            calEn_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            sat_d    = 1'b0;
        end
    end

    assign cal.cal_en = calEn_q;
    assign cal.trim   = trim_q;
    assign cal.busy   = busy_q;
    assign cal.done   = done_q;
    assign cal.sat    = sat_q;
endmodule

// File: doc/cmp_offset_cal.md
Name: cmp_offset_cal

Overview:
- Clocked successive-approximation (SAR) calibration controller for a PWL slicer (pwl2bit-style comparator).
- Drives a binary trim code to the slicer's offset DAC while the slicer input is shorted (`cal_en`).
- Resolves each trim bit by majority vote of the slicer output, then holds the final code for mission mode.
- Sits between the digital test/boot sequencer and the analog slicer model.

Parameters:
- NBIT, 6, trim code width; legal range 2..10.
- SETTLE_CYC, 4, wait cycles after each trim change before voting; must be ≥2 to cover the synchronizer.
- NVOTE, 3, slicer samples per bit decision; must be odd, legal range 1..15.
- TRIM_RST, 2**(NBIT-1), trim value held from reset until the first calibration finishes.

Ports:
- clk, input, 1, system clock; rising edge active.
- rstb, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that requests a calibration run.
- abort, input, 1, level input that cancels a run in progress.
- cmp_out, input, 1, slicer logic output; asynchronous to clk.
- cal_en, output, 1, high while calibrating; shorts the slicer input and selects the trim DAC.
- trim, output, NBIT, offset-DAC code applied to the slicer.
- busy, output, 1, high from run start until DONE or abort.
- done, output, 1, high once a run completes; stays high until the next accepted start or reset.
- sat, output, 1, final code is all-zeros or all-ones; valid while done=1.

Behaviour:
- Reset (rstb=0, asynchronous):
  - state=IDLE, trim=TRIM_RST, cal_en=0, busy=0, done=0, sat=0.
  - Synchronizer flops, counters and bit index all cleared.
- cmp_out passes through a 2-flop synchronizer; only the synced value cmp_s is used.
- States are IDLE, SETTLE, VOTE, DECIDE, DONE.
- IDLE:
  - start=1 and abort=0 → go to SETTLE.
  - On that transition: trim=1<<(NBIT-1), bit index k=NBIT-1, cal_en=1, busy=1, done=0, sat=0, settle counter=0.
  - start is ignored in every state other than IDLE.
- SETTLE:
  - Counts SETTLE_CYC cycles, then moves to VOTE.
  - On entry to VOTE the ones-counter is cleared.
- VOTE:
  - Samples cmp_s for NVOTE consecutive cycles; the ones-counter increments when cmp_s=1.
  - Counter width is clog2(NVOTE+1).
  - After NVOTE cycles, go to DECIDE.
- DECIDE (1 cycle):
  - hi = (ones > NVOTE/2).
  - If hi, clear trim[k].
  - If k>0, set trim[k-1], decrement k, go to SETTLE.
  - If k=0, go to DONE.
- DONE (1 cycle):
  - cal_en=0, busy=0, done=1.
  - sat = (trim==0) || (trim=={NBIT{1'b1}}).
  - Go to IDLE; trim is held.
- Latency: done rises NBIT*(SETTLE_CYC+NVOTE+1)+1 clk edges after the edge that samples start. With defaults this is 49.
- Result: trim is the largest code for which the slicer votes low (0).
- abort=1 in SETTLE, VOTE or DECIDE:
  - Next edge → IDLE with cal_en=0, busy=0, done=0.
  - trim is restored to its value from before the run: the last calibrated code, or TRIM_RST if no run has completed.
  - abort has priority over start and over the DECIDE update in the same cycle.
- A pre-run trim shadow register holds the restore value for abort.
- trim changes only in the IDLE→SETTLE transition, in DECIDE, and on abort restore. It is glitch-free (registered).
- Reset mid-run discards the run; outputs return to reset values immediately.

Decomposition:
- Package cmp_cal_pkg holds:
  - state enum cal_state_t {IDLE, SETTLE, VOTE, DECIDE, DONE};
  - function clog2 for counter widths.
- One sub-module, sync2: 2-flop synchronizer with async active-low reset to 0, instanced for cmp_out.
- Top-level FSM, counters and trim register live in cmp_offset_cal.

Test Plan:
1. Defaults. Slicer model cmp_out = (trim ≥ 38). Pulse start → trim walks 32,48,40,36,38,37. done=1 at cycle 49, trim=37, sat=0, busy=0, cal_en=0.
2. Slicer model cmp_out stuck 1 → final trim=0, sat=1. Slicer model cmp_out stuck 0 → final trim=63, sat=1.
3. Noisy vote, NVOTE=3: during the bit-5 vote inject samples 1,0,1 → bit 5 cleared. Inject 0,1,0 → bit 5 kept.
4. Complete a run with trim=37. Start a second run; assert abort on cycle 20 → next edge IDLE, trim=37, done=0, busy=0, cal_en=0.
5. Drop rstb mid-VOTE, asynchronous to clk → trim=32, cal_en=0, busy=0 immediately. Releasing rstb and pulsing start gives a full 49-cycle run.
6. Pulse start while busy=1 → ignored; done still rises at the original cycle 49. start and abort in the same IDLE cycle → stays IDLE.
